// File: rtl/ex_muldiv.sv
// Iterative 32-bit multiply/divide unit for the EX stage: MULT/MULTU/DIV/DIVU into HI/LO,
// plus MTHI/MTLO writes. One result bit per cycle, 32 iterations.
module ex_muldiv (
  input  logic        Clock_i,
  input  logic        Reset_i,
  input  logic        Start_i,
  input  logic [1:0]  Op_i,
  input  logic [31:0] Data1_i,
  input  logic [31:0] Data2_i,
  input  logic        HiWrite_i,
  input  logic        LoWrite_i,
  input  logic [31:0] WriteData_i,
  output logic        Busy_o,
  output logic        Done_o,
  output logic [31:0] Hi_o,
  output logic [31:0] Lo_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic        is_div;
  logic        neg_res;   // product / quotient sign
  logic        neg_rem;   // remainder follows dividend sign
  logic [31:0] opnd;      // multiplicand magnitude (MUL) or divisor magnitude (DIV)
  logic [63:0] prod;      // high half accumulates, low half shifts out multiplier bits
  logic [32:0] rem;
  logic [31:0] quot;      // dividend shifts out of the top while quotient bits shift in

  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [32:0] div_diff;
  logic [63:0] prod_fin;
  logic [31:0] quot_fin;
  logic [31:0] rem_fin;

  // NOTE: every always_comb output is assigned a default first so no path can infer a latch.
  always_comb begin
    signed_op = ~Op_i[0];
    a_neg     = signed_op & Data1_i[31];
    b_neg     = signed_op & Data2_i[31];
    a_mag     = a_neg ? (~Data1_i + 32'd1) : Data1_i;
    b_mag     = b_neg ? (~Data2_i + 32'd1) : Data2_i;
    mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);
    div_shift = {rem[31:0], quot[31]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_diff  = div_shift - {1'b0, opnd};
    prod_fin  = neg_res ? (~prod + 64'd1) : prod;
    quot_fin  = neg_res ? (~quot + 32'd1) : quot;
    rem_fin   = neg_rem ? (~rem[31:0] + 32'd1) : rem[31:0];
  end

  assign Busy_o = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state   <= IDLE;
      cnt     <= 6'd0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      opnd    <= 32'd0;
      prod    <= 64'd0;
      rem     <= 33'd0;
      quot    <= 32'd0;
      Done_o  <= 1'b0;
      Hi_o    <= 32'd0;
      Lo_o    <= 32'd0;
    end else begin
      Done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (Start_i) begin
            cnt     <= 6'd0;
            is_div  <= Op_i[1];
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            if (!Op_i[1]) begin
              opnd  <= a_mag;
              prod  <= {32'd0, b_mag};
              state <= MUL;
            end else if (Data2_i == 32'd0) begin
              // Divide by zero: preload the architectural result and skip iterations
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
              quot    <= 32'hFFFF_FFFF;
              rem     <= {1'b0, Data1_i};
              state   <= FIN;
            end else begin
              opnd  <= b_mag;
              quot  <= a_mag;
              rem   <= 33'd0;
              state <= DIV;
            end
          end else begin
            if (HiWrite_i) Hi_o <= WriteData_i;
            if (LoWrite_i) Lo_o <= WriteData_i;
          end
        end
        MUL: begin
          prod <= {mul_sum, prod[31:1]};
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIN;
        end
        DIV: begin
          rem  <= div_ge ? div_diff : div_shift;
          quot <= {quot[30:0], div_ge};
          cnt  <= cnt + 6'd1;
          if (cnt == 6'd31) state <= FIN;
        end
        FIN: begin
          if (is_div) begin
            Lo_o <= quot_fin;
            Hi_o <= rem_fin;
          end else begin
            Hi_o <= prod_fin[63:32];
            Lo_o <= prod_fin[31:0];
          end
          Done_o <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Multi-cycle multiply/divide unit in the EX stage, fed directly from the ID/EX pipeline register (operands from Data1/Data2, start and opcode decoded from the EX control field). Computes MULT/MULTU/DIV/DIVU iteratively into architectural HI/LO registers and reports busy status to hazard detection, so MFHI/MFLO stall until the result is ready. Also services MTHI/MTLO writes.

## Interface
- No parameters; datapath fixed at 32 bits, 32 iterations.
- Clock_i  in  1  pipeline clock; all state updates on rising edge.
- Reset_i  in  1  asynchronous, active-high reset.
- Start_i  in  1  request a mul/div operation this cycle.
- Op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- Data1_i  in  32  rs operand (multiplicand / dividend).
- Data2_i  in  32  rt operand (multiplier / divisor).
- HiWrite_i  in  1  MTHI: load WriteData_i into HI.
- LoWrite_i  in  1  MTLO: load WriteData_i into LO.
- WriteData_i  in  32  data for MTHI/MTLO.
- Busy_o  out  1  operation in progress; HI/LO not valid.
- Done_o  out  1  one-cycle pulse: HI/LO just updated by mul/div.
- Hi_o  out  32  HI register.
- Lo_o  out  32  LO register.

## Operation
- States: IDLE, MUL, DIV, FIN. Iteration counter 6 bits.
- IDLE + Start_i at edge: latch operand magnitudes (abs value for signed ops, raw for unsigned), latch result sign flags, clear counter; go MUL (Op_i[1]=0) or DIV (Op_i[1]=1).
- DIV with Data2_i = 0: skip iterations, go FIN directly; FIN writes Lo = 32'hFFFFFFFF, Hi = Data1_i (raw, unsigned view).
- MUL: radix-2 shift-add, one bit per cycle, 64-bit product accumulator; 32 cycles then FIN.
- DIV: restoring division, one quotient bit per cycle, 33-bit partial remainder; 32 cycles then FIN.
- FIN: apply sign, write HI/LO, pulse Done_o, go IDLE.
  - MULT: negate 64-bit product if signs of operands differ. {Hi,Lo} = product.
  - DIV: Lo = quotient, negated if operand signs differ; Hi = remainder, negated if dividend negative.
  - Signed 0x80000000 / 0xFFFFFFFF: Lo = 0x80000000, Hi = 0 (falls out of magnitude method; no trap).
  - Unsigned ops never negate.
- HiWrite_i/LoWrite_i: honoured only in IDLE and only when Start_i is low; both may write in the same cycle. Ignored while Busy_o.
- Start_i while not IDLE: ignored (hazard unit prevents it; must not corrupt state).
- Start_i and HiWrite_i/LoWrite_i together in IDLE: Start wins, writes dropped.

## Timing
- Reset (async, any state): state IDLE, counter 0, Hi_o = 0, Lo_o = 0, Busy_o = 0, Done_o = 0; in-flight operation discarded.
- Busy_o = (state != IDLE), decoded from registered state; no combinational path from Start_i.
- Accept edge = E0. MUL/DIV: iterations at edges E1..E32, FIN at E33; Hi_o/Lo_o new value and Done_o = 1 in cycle after E33; Busy_o high from after E0 through E33. Latency 33 cycles, next Start_i accepted at E34 at earliest... Start_i sampled in the cycle after E33 is accepted (state IDLE).
- Divide-by-zero: FIN at E1, Busy_o high one cycle, Done_o in cycle after E1.
- Done_o high exactly one cycle per completed operation; never for MTHI/MTLO.
- MTHI/MTLO: Hi_o/Lo_o update at the accepting edge, visible next cycle.
- Hi_o/Lo_o hold previous values throughout an operation; only FIN changes them.
- Hazard contract: MFHI/MFLO in ID must stall while Busy_o or while Start_i is high in EX.

## Test plan
- Reset, then MULT 0xFFFFFFFE × 3 (-2×3) -> Busy_o 33 cycles, Done_o 1 cycle, Hi = 0xFFFFFFFF, Lo = 0xFFFFFFFA; MULTU same operands -> Hi = 0x00000002, Lo = 0xFFFFFFFA.
- DIV -7 / 2 -> Lo = 0xFFFFFFFD (-3), Hi = 0xFFFFFFFF (-1); DIVU 100 / 7 -> Lo = 14, Hi = 2; DIV 0x80000000 / -1 -> Lo = 0x80000000, Hi = 0.
- DIVU 5 / 0 -> Busy_o exactly 1 cycle, Lo = 0xFFFFFFFF, Hi = 5.
- Start MULT, pulse Start_i and HiWrite_i mid-operation -> ignored, final result unchanged, Done_o single pulse; MTLO 0x1234 in IDLE -> Lo = 0x1234, Done_o stays 0.
- Assert Reset_i at iteration 10 of a DIV -> immediately Busy_o = 0, Hi = Lo = 0; new MULTU 0xFFFFFFFF × 0xFFFFFFFF after release -> Hi = 0xFFFFFFFE, Lo = 0x00000001.
- Back-to-back: Start_i in the cycle Done_o is high -> accepted, second result correct, no lost Done_o.
